// File: rtl/cpu_defs.sv
// Payload layout shared by IF and ID; the instruction queue itself only
// sees the flattened ENTRY_W-bit vector.
package cpu_defs;

    localparam int PC_W       = 32;
    localparam int INST_W     = 32;
    localparam int EXC_W      = 8;
    localparam int IQ_ENTRY_W = PC_W + INST_W + EXC_W;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
        logic [EXC_W-1:0]  exception;
    } iq_entry_t;

endpackage

// File: rtl/id_inst_queue_if.sv
// Fetch/decode side of the instruction queue: push lanes, pop lanes, flush
// control and occupancy.
interface id_inst_queue_if
    import cpu_defs::*;
#(
    parameter int DEPTH   = 8,
    parameter int IN_W    = 2,
    parameter int OUT_W   = 2,
    parameter int ENTRY_W = IQ_ENTRY_W
);

    logic [IN_W-1:0]               in_valid;
    logic [IN_W*ENTRY_W-1:0]       in_data;
    logic                          in_ready;
    logic [OUT_W-1:0]              out_valid;
    logic [OUT_W*ENTRY_W-1:0]      out_data;
    logic [$clog2(OUT_W+1)-1:0]    out_pop;
    logic                          flush;
    logic [$clog2(OUT_W+1)-1:0]    keep_n;
    logic [$clog2(DEPTH+1)-1:0]    count;

    modport master (
        output in_valid, in_data, out_pop, flush, keep_n,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  in_valid, in_data, out_pop, flush, keep_n,
        output in_ready, out_valid, out_data, count
    );

endinterface

// File: rtl/iq_popcount.sv
// Counts set bits of a lane mask and flags whether the mask is a prefix
// (no valid lane above an invalid one).
module iq_popcount #(
    parameter int W = 2
) (
    input  logic [W-1:0]             bits,
    output logic [$clog2(W+1)-1:0]   cnt,
    output logic                     prefix_ok
);

    localparam int CW = $clog2(W + 1);

    always_comb begin
        cnt = '0;
        for (int unsigned i = 0; i < W; i++) begin
            cnt = cnt + CW'(bits[i]);
        end
    end

    always_comb begin
        prefix_ok = 1'b1;
        for (int unsigned i = 1; i < W; i++) begin
            if (bits[i] && !bits[i-1]) begin
                prefix_ok = 1'b0;
            end
        end
    end

endmodule

// File: rtl/id_inst_queue.sv
// Fetch-to-decode instruction buffer: DEPTH-entry circular FIFO with
// multi-lane push/pop and a flush that can retain the oldest survivors.
module id_inst_queue
    import cpu_defs::*;
#(
    parameter int DEPTH   = 8,
    parameter int IN_W    = 2,
    parameter int OUT_W   = 2,
    parameter int ENTRY_W = IQ_ENTRY_W
) (
    input logic          clk,
    input logic          reset,
    id_inst_queue_if.slave q
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(IN_W + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("id_inst_queue: DEPTH must be a power of two >= 2");
    end
    if (DEPTH < IN_W || DEPTH < OUT_W) begin : g_bad_width
        $error("id_inst_queue: DEPTH must be >= IN_W and >= OUT_W");
    end

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PW-1:0]      head_q;
    logic [PW-1:0]      tail_q;
    logic [CW-1:0]      count_q;

    logic [IW-1:0]      push_n;
    logic               prefix_ok;
    logic               in_ready;
    logic               push_fire;
    logic [CW-1:0]      pop_req;
    logic [CW-1:0]      pop_cnt;
    logic [CW-1:0]      remain;
    logic [CW-1:0]      keep_req;
    logic [CW-1:0]      keep_cnt;
    logic [CW-1:0]      push_cnt;
    logic [PW-1:0]      head_pop;

    iq_popcount #(.W(IN_W)) u_push_cnt (
        .bits      (q.in_valid),
        .cnt       (push_n),
        .prefix_ok (prefix_ok)
    );

    // Ready depends on registered occupancy only, so a same-cycle pop never
    // opens the input and there is no path from out_pop/flush to in_ready.
    always_comb begin
        in_ready  = count_q <= CW'(DEPTH - IN_W);
        push_fire = in_ready && (|q.in_valid);
        pop_req   = CW'(q.out_pop);
        pop_cnt   = (pop_req < count_q) ? pop_req : count_q;
        remain    = count_q - pop_cnt;
        keep_req  = CW'(q.keep_n);
        keep_cnt  = (keep_req < remain) ? keep_req : remain;
        push_cnt  = push_fire ? CW'(push_n) : '0;
        head_pop  = head_q + PW'(pop_cnt);
    end

    assign q.in_ready = in_ready;
    assign q.count    = count_q;

    always_comb begin
        q.out_valid = '0;
        q.out_data  = '0;
        for (int unsigned i = 0; i < OUT_W; i++) begin
            q.out_valid[i] = count_q > CW'(i);
            if (count_q > CW'(i)) begin
                q.out_data[i*ENTRY_W +: ENTRY_W] = mem[head_q + PW'(i)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (q.flush) begin
            head_q  <= head_pop;
            tail_q  <= head_pop + PW'(keep_cnt);
            count_q <= keep_cnt;
        end else begin
            head_q  <= head_pop;
            tail_q  <= tail_q + PW'(push_cnt);
            count_q <= count_q - pop_cnt + push_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !q.flush && push_fire) begin
            for (int unsigned i = 0; i < IN_W; i++) begin
                if (IW'(i) < push_n) begin
                    mem[tail_q + PW'(i)] <= q.in_data[i*ENTRY_W +: ENTRY_W];
                end
            end
        end
    end

    a_in_valid_prefix: assert property (@(posedge clk) disable iff (reset) prefix_ok);

endmodule

// File: tb/tb_id_inst_queue.sv
// Bench for id_inst_queue: directed vector table, flush sequences and a
// randomized stream, all checked against a queue-based reference model.
module tb_id_inst_queue;
    import cpu_defs::*;

    localparam int DEPTH = 8;
    localparam int IN_W  = 2;
    localparam int OUT_W = 2;
    localparam int EW    = IQ_ENTRY_W;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_inst_queue_if #(.DEPTH(DEPTH), .IN_W(IN_W), .OUT_W(OUT_W), .ENTRY_W(EW)) qi ();

    id_inst_queue #(.DEPTH(DEPTH), .IN_W(IN_W), .OUT_W(OUT_W), .ENTRY_W(EW)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (qi)
    );

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [EW-1:0] mq [$];

    typedef struct {
        logic [1:0]  vld;
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic [1:0]  pop;
        logic        fl;
        logic [1:0]  kn;
        logic        rst;
        int unsigned e_cnt;
        logic        e_rdy;
        logic [1:0]  e_vld;
        logic        chk_pc;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl [11];

    function automatic logic [EW-1:0] mk(input logic [31:0] pc);
        iq_entry_t e;
        e.pc        = pc;
        e.inst      = pc ^ 32'h0bad_f00d;
        e.exception = pc[9:2];
        return e;
    endfunction

    task automatic chk(input string nm, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic check_model();
        int unsigned n;
        n = mq.size();
        chk("count", qi.count, n);
        chk("in_ready", qi.in_ready, n <= DEPTH - IN_W);
        for (int i = 0; i < OUT_W; i++) begin
            chk($sformatf("out_valid%0d", i), qi.out_valid[i], n > i);
            chk($sformatf("out_data%0d", i), qi.out_data[i*EW +: EW], (n > i) ? mq[i] : '0);
        end
    endtask

    // One clock: drive, compare pre-edge outputs with the model, advance model.
    task automatic cycle(input logic [1:0] vld, input logic [31:0] pc0, input logic [31:0] pc1,
                         input logic [1:0] pop, input logic fl, input logic [1:0] kn, input logic rst);
        int unsigned p;
        int unsigned n0;
        logic rdy;
        qi.in_valid = vld;
        qi.in_data  = {mk(pc1), mk(pc0)};
        qi.out_pop  = pop;
        qi.flush    = fl;
        qi.keep_n   = kn;
        reset       = rst;
        assert (vld != 2'b10) else $error("bench drove non-prefix in_valid");
        #1;
        check_model();
        n0  = mq.size();
        rdy = n0 <= DEPTH - IN_W;
        assert (rst || pop <= n0) else $error("bench over-popped");
        @(posedge clk);
        if (rst) begin
            mq.delete();
        end else begin
            p = (pop < n0) ? pop : n0;
            repeat (p) void'(mq.pop_front());
            if (fl) begin
                while (mq.size() > kn) void'(mq.pop_back());
            end else if (rdy && vld != 2'b00) begin
                mq.push_back(mk(pc0));
                if (vld[1]) mq.push_back(mk(pc1));
            end
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned pushed;
        int unsigned popped;
        int unsigned cyc;
        logic [31:0] base;
        logic [31:0] exp_pc;

        tbl[0]  = '{2'b00, 32'h0,         32'h0,         2'd0, 1'b0, 2'd0, 1'b1, 0, 1'b1, 2'b00, 1'b0, 32'h0};
        tbl[1]  = '{2'b11, 32'hbfc00000, 32'hbfc00004, 2'd0, 1'b0, 2'd0, 1'b0, 2, 1'b1, 2'b11, 1'b1, 32'hbfc00000};
        tbl[2]  = '{2'b11, 32'hbfc00008, 32'hbfc0000c, 2'd0, 1'b0, 2'd0, 1'b0, 4, 1'b1, 2'b11, 1'b1, 32'hbfc00000};
        tbl[3]  = '{2'b11, 32'hbfc00010, 32'hbfc00014, 2'd0, 1'b0, 2'd0, 1'b0, 6, 1'b1, 2'b11, 1'b1, 32'hbfc00000};
        tbl[4]  = '{2'b11, 32'hbfc00018, 32'hbfc0001c, 2'd0, 1'b0, 2'd0, 1'b0, 8, 1'b0, 2'b11, 1'b1, 32'hbfc00000};
        tbl[5]  = '{2'b11, 32'hbfc000f0, 32'hbfc000f4, 2'd0, 1'b0, 2'd0, 1'b0, 8, 1'b0, 2'b11, 1'b1, 32'hbfc00000};
        tbl[6]  = '{2'b00, 32'h0,         32'h0,         2'd2, 1'b0, 2'd0, 1'b0, 6, 1'b1, 2'b11, 1'b1, 32'hbfc00008};
        tbl[7]  = '{2'b11, 32'hbfc00020, 32'hbfc00024, 2'd2, 1'b0, 2'd0, 1'b0, 6, 1'b1, 2'b11, 1'b1, 32'hbfc00010};
        tbl[8]  = '{2'b01, 32'hbfc00028, 32'h0,         2'd0, 1'b0, 2'd0, 1'b0, 7, 1'b0, 2'b11, 1'b1, 32'hbfc00010};
        tbl[9]  = '{2'b11, 32'hbfc00030, 32'hbfc00034, 2'd2, 1'b0, 2'd0, 1'b0, 5, 1'b1, 2'b11, 1'b1, 32'hbfc00018};
        tbl[10] = '{2'b11, 32'hbfc00040, 32'hbfc00044, 2'd0, 1'b1, 2'd0, 1'b1, 0, 1'b1, 2'b00, 1'b0, 32'h0};

        qi.in_valid = '0;
        qi.in_data  = '0;
        qi.out_pop  = '0;
        qi.flush    = 1'b0;
        qi.keep_n   = '0;
        reset       = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].vld, tbl[i].pc0, tbl[i].pc1, tbl[i].pop, tbl[i].fl, tbl[i].kn, tbl[i].rst);
            chk($sformatf("tbl%0d_count", i), qi.count, tbl[i].e_cnt);
            chk($sformatf("tbl%0d_ready", i), qi.in_ready, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_valid", i), qi.out_valid, tbl[i].e_vld);
            if (tbl[i].chk_pc) chk($sformatf("tbl%0d_pc0", i), qi.out_data[EW-1 -: 32], tbl[i].e_pc);
        end
        chk("reset_head", dut.head_q, 0);
        chk("reset_tail", dut.tail_q, 0);

        // Flush keeping one survivor after a pop, with a same-cycle push.
        cycle(2'b11, 32'h100, 32'h104, 2'd0, 1'b0, 2'd0, 1'b0);
        cycle(2'b11, 32'h108, 32'h10c, 2'd0, 1'b0, 2'd0, 1'b0);
        cycle(2'b11, 32'h200, 32'h204, 2'd1, 1'b1, 2'd1, 1'b0);
        chk("flush_count", qi.count, 1);
        chk("flush_lane0_pc", qi.out_data[EW-1 -: 32], 32'h104);
        chk("flush_lane1_valid", qi.out_valid[1], 1'b0);
        cycle(2'b01, 32'h300, 32'h0, 2'd0, 1'b0, 2'd0, 1'b0);
        chk("flush_push_lane1_pc", qi.out_data[2*EW-1 -: 32], 32'h300);
        // keep_n larger than what survives the pop: retains only the remainder.
        cycle(2'b00, 32'h0, 32'h0, 2'd1, 1'b1, 2'd2, 1'b0);
        chk("flush_keep_clamp_count", qi.count, 1);
        chk("flush_keep_clamp_pc", qi.out_data[EW-1 -: 32], 32'h300);
        cycle(2'b00, 32'h0, 32'h0, 2'd0, 1'b1, 2'd0, 1'b0);
        chk("flush_empty_count", qi.count, 0);

        // Random stream across pointer wrap.
        base   = 32'h8000_0000;
        exp_pc = base;
        pushed = 0;
        popped = 0;
        cyc    = 0;
        while ((pushed < 20 || mq.size() > 0) && cyc < 500) begin
            logic [1:0] v;
            logic [1:0] pp;
            int unsigned sz;
            logic rdy;
            sz  = mq.size();
            rdy = sz <= DEPTH - IN_W;
            if (pushed >= 20) v = 2'b00;
            else if (pushed == 19) v = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b00;
            else begin
                case ($urandom_range(0, 2))
                    0: v = 2'b00;
                    1: v = 2'b01;
                    default: v = 2'b11;
                endcase
            end
            pp = 2'($urandom_range(0, (sz < 2) ? sz : 2));
            for (int k = 0; k < int'(pp); k++) begin
                chk("stream_pc", qi.out_data[k*EW + EW-1 -: 32], exp_pc);
                exp_pc = exp_pc + 32'd4;
                popped++;
            end
            cycle(v, base + 32'(4 * pushed), base + 32'(4 * pushed + 4), pp, 1'b0, 2'd0, 1'b0);
            if (rdy && v != 2'b00) pushed += v[1] ? 2 : 1;
            cyc++;
        end
        chk("stream_popped_total", popped, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
